sound_event_sched: RTL and testbench

Sound-event scheduler sitting directly upstream of the buzzer music player. Latches one-cycle game sound requests (game start, pellet, ghost eaten, Pac-Man death), arbitrates them by fixed priority, and drives the player's 2-bit song select and level-held start. Ends each song on the player's end-of-song pulse, enforces a reset gap between songs, supports preemption by higher-priority events, and raises a completion interrupt to the CPU.

---
 rtl/sound_event_sched.sv | 136 +++++++++++++
 tb/tb_sound_event_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_sched.sv
// Sound-event scheduler: latches game sound requests, arbitrates by fixed priority
// and sequences the buzzer player through load / play / reset-gap phases.
module sound_event_sched #(
   parameter int unsigned GAP_CYCLES     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ev_req,
   input  logic       mute,
   input  logic       song_end,
   output logic [1:0] music_select,
   output logic       music_start,
   output logic       busy,
   output logic [1:0] cur_song,
   output logic       done_irq,
   output logic       abort_irq
);

   localparam int unsigned GAP_W = 16;
   localparam int unsigned WD_W  = 32;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP
   } state_t;

   state_t           state;
   logic [3:0]       pend;
   logic [GAP_W-1:0] gap_cnt;
   logic [WD_W-1:0]  wd_cnt;

   logic [3:0] pend_eff;
   logic [3:0] pend_nxt;
   logic [3:0] launch_clr;
   logic [3:0] higher_mask;
   logic [1:0] winner;
   logic       preempt;

   // Same-cycle requests count as pending so a launch or preemption reacts immediately.
   always_comb begin
      pend_eff    = pend | ev_req;
      winner      = 2'd0;
      launch_clr  = 4'b0000;
      higher_mask = 4'b0000;

      if (pend[3])      winner = 2'd3;
      else if (pend[2]) winner = 2'd2;
      else if (pend[1]) winner = 2'd1;
      else              winner = 2'd0;

      if (state == S_LOAD) launch_clr = 4'b0001 << winner;

      case (cur_song)
         2'd0:    higher_mask = 4'b1110;
         2'd1:    higher_mask = 4'b1100;
         2'd2:    higher_mask = 4'b1000;
         default: higher_mask = 4'b0000;
      endcase

      preempt  = |(pend_eff & higher_mask);
      // New requests win over a same-cycle clear.
      pend_nxt = (pend & ~(mute ? 4'b1111 : launch_clr)) | ev_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         pend         <= 4'b0000;
         gap_cnt      <= '0;
         wd_cnt       <= '0;
         music_select <= 2'd0;
         music_start  <= 1'b0;
         busy         <= 1'b0;
         cur_song     <= 2'd0;
         done_irq     <= 1'b0;
         abort_irq    <= 1'b0;
      end else begin
         pend      <= pend_nxt;
         done_irq  <= 1'b0;
         abort_irq <= 1'b0;

         case (state)
            S_IDLE: begin
               if ((pend_eff != 4'b0000) && !mute) begin
                  state <= S_LOAD;
                  busy  <= 1'b1;
               end
            end

            S_LOAD: begin
               music_select <= winner;
               cur_song     <= winner;
               wd_cnt       <= '0;
               music_start  <= 1'b1;
               state        <= S_PLAY;
            end

            S_PLAY: begin
               wd_cnt <= wd_cnt + WD_W'(1);
               // Exit causes are ranked: normal end, mute, preemption, watchdog.
               if (song_end) begin
                  done_irq    <= 1'b1;
                  music_start <= 1'b0;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
               end else if (mute || preempt || (wd_cnt == WD_LAST)) begin
                  abort_irq   <= 1'b1;
                  music_start <= 1'b0;
                  gap_cnt     <= '0;
                  state       <= S_GAP;
               end
            end

            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sound_event_sched.sv
// Directed bench for sound_event_sched; observed bus = {busy, start, select, cur_song, done, abort}.
module tb_sound_event_sched;

   localparam int unsigned GAP = 8;
   localparam int unsigned TMO = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ev_req;
   logic       mute;
   logic       song_end;
   logic [1:0] music_select;
   logic       music_start;
   logic       busy;
   logic [1:0] cur_song;
   logic       done_irq;
   logic       abort_irq;
   logic [7:0] obs;

   int tests = 0;
   int fails = 0;

   sound_event_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ev_req(ev_req), .mute(mute), .song_end(song_end),
      .music_select(music_select), .music_start(music_start), .busy(busy),
      .cur_song(cur_song), .done_irq(done_irq), .abort_irq(abort_irq)
   );

   assign obs = {busy, music_start, music_select, cur_song, done_irq, abort_irq};

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse song_end and wait until the scheduler is back in IDLE.
   task automatic end_song();
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      repeat (GAP) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; ev_req = 4'b0; mute = 1'b0; song_end = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tests++;
      if (obs !== 8'b0000_0000) begin fails++; $display("FAIL reset_outputs obs=%b exp=%b", obs, 8'b0); end
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      tests++;
      if (obs !== 8'b0000_0000) begin fails++; $display("FAIL idle_song_end obs=%b exp=%b", obs, 8'b0); end
   endtask

   task automatic test_basic();
      ev_req = 4'b0010;
      tick();
      ev_req = 4'b0;
      tests++;
      if (obs !== 8'b1000_0000) begin fails++; $display("FAIL basic_load obs=%b exp=%b", obs, 8'b1000_0000); end
      tick();
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (obs !== 8'b1101_0100) begin fails++; $display("FAIL basic_play[%0d] obs=%b exp=%b", i, obs, 8'b1101_0100); end
         tick();
      end
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      tests++;
      if (obs !== 8'b1001_0110) begin fails++; $display("FAIL basic_done obs=%b exp=%b", obs, 8'b1001_0110); end
      for (int i = 1; i < int'(GAP); i++) begin
         tick();
         tests++;
         if (obs !== 8'b1001_0100) begin fails++; $display("FAIL basic_gap[%0d] obs=%b exp=%b", i, obs, 8'b1001_0100); end
      end
      tick();
      tests++;
      if (obs !== 8'b0001_0100) begin fails++; $display("FAIL basic_idle obs=%b exp=%b", obs, 8'b0001_0100); end
   endtask

   task automatic test_preempt();
      int bad;
      ev_req = 4'b0001;
      tick();
      ev_req = 4'b0;
      tick();
      tests++;
      if (obs !== 8'b1100_0000) begin fails++; $display("FAIL pre_play0 obs=%b exp=%b", obs, 8'b1100_0000); end
      repeat (3) tick();
      ev_req = 4'b1000;
      tick();
      ev_req = 4'b0;
      tests++;
      if (obs !== 8'b1000_0001) begin fails++; $display("FAIL pre_abort obs=%b exp=%b", obs, 8'b1000_0001); end
      bad = 0;
      for (int i = 1; i < int'(GAP); i++) begin
         tick();
         if (obs !== 8'b1000_0000) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL pre_gap bad_cycles=%0d exp=0", bad); end
      tick();
      tests++;
      if (obs !== 8'b0000_0000) begin fails++; $display("FAIL pre_idle obs=%b exp=%b", obs, 8'b0000_0000); end
      tick();
      tick();
      tests++;
      if (obs !== 8'b1111_1100) begin fails++; $display("FAIL pre_play3 obs=%b exp=%b", obs, 8'b1111_1100); end
      song_end = 1'b1;
      tick();
      song_end = 1'b0;
      tests++;
      if (obs !== 8'b1011_1110) begin fails++; $display("FAIL pre_done3 obs=%b exp=%b", obs, 8'b1011_1110); end
      repeat (GAP) tick();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (obs !== 8'b0011_1100) bad++;
         tick();
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL pre_no_replay bad_cycles=%0d exp=0", bad); end
   endtask

   task automatic test_coalesce();
      int busy_cnt;
      ev_req = 4'b0100;
      tick();
      ev_req = 4'b0;
      tick();
      tests++;
      if (obs !== 8'b1110_1000) begin fails++; $display("FAIL coal_play2 obs=%b exp=%b", obs, 8'b1110_1000); end
      repeat (5) begin
         ev_req = 4'b0001;
         tick();
         ev_req = 4'b0;
         tick();
      end
      tests++;
      if (obs !== 8'b1110_1000) begin fails++; $display("FAIL coal_still2 obs=%b exp=%b", obs, 8'b1110_1000); end
      end_song();
      tests++;
      if (obs !== 8'b0010_1000) begin fails++; $display("FAIL coal_idle obs=%b exp=%b", obs, 8'b0010_1000); end
      tick();
      tick();
      tests++;
      if (obs !== 8'b1100_0000) begin fails++; $display("FAIL coal_play0 obs=%b exp=%b", obs, 8'b1100_0000); end
      end_song();
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) busy_cnt++;
         tick();
      end
      tests++;
      if (busy_cnt !== 0) begin fails++; $display("FAIL coal_single_launch busy_cycles=%0d exp=0", busy_cnt); end
   endtask

   task automatic test_all4();
      int low;
      logic [1:0] s2;
      ev_req = 4'b1111;
      tick();
      ev_req = 4'b0;
      tick();
      for (int s = 3; s >= 0; s--) begin
         s2 = 2'(s);
         tests++;
         if (obs !== {2'b11, s2, s2, 2'b00}) begin fails++; $display("FAIL all4_play%0d obs=%b exp=%b", s, obs, {2'b11, s2, s2, 2'b00}); end
         repeat (3) tick();
         if (s == 0) begin
            end_song();
         end else begin
            song_end = 1'b1;
            tick();
            song_end = 1'b0;
            low = 1;
            for (int i = 0; i < int'(GAP) + 10; i++) begin
               tick();
               if (music_start) break;
               low++;
            end
            tests++;
            if (low !== int'(GAP) + 2) begin fails++; $display("FAIL all4_gap%0d low=%0d exp=%0d", s, low, GAP + 2); end
         end
      end
      tests++;
      if (obs !== 8'b0000_0000) begin fails++; $display("FAIL all4_idle obs=%b exp=%b", obs, 8'b0000_0000); end
   endtask

   task automatic test_mute();
      int hi;
      ev_req = 4'b0100;
      tick();
      ev_req = 4'b0;
      tick();
      ev_req = 4'b0011;
      tick();
      ev_req = 4'b0;
      tests++;
      if (obs !== 8'b1110_1000) begin fails++; $display("FAIL mute_play2 obs=%b exp=%b", obs, 8'b1110_1000); end
      tick();
      mute = 1'b1;
      tick();
      tests++;
      if (obs !== 8'b1010_1001) begin fails++; $display("FAIL mute_abort obs=%b exp=%b", obs, 8'b1010_1001); end
      hi = 0;
      for (int i = 0; i < int'(GAP) + 15; i++) begin
         tick();
         if (music_start) hi++;
      end
      tests++;
      if (hi !== 0) begin fails++; $display("FAIL mute_no_start start_cycles=%0d exp=0", hi); end
      tests++;
      if (obs !== 8'b0010_1000) begin fails++; $display("FAIL mute_idle obs=%b exp=%b", obs, 8'b0010_1000); end
      mute = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) hi++;
      end
      tests++;
      if (hi !== 0) begin fails++; $display("FAIL mute_pend_cleared busy_cycles=%0d exp=0", hi); end
   endtask

   task automatic test_timeout_rst();
      int bad;
      ev_req = 4'b0001;
      tick();
      ev_req = 4'b0;
      tick();
      tests++;
      if (obs !== 8'b1100_0000) begin fails++; $display("FAIL tmo_play obs=%b exp=%b", obs, 8'b1100_0000); end
      bad = 0;
      for (int i = 1; i < int'(TMO); i++) begin
         ev_req = (i == 50) ? 4'b0001 : 4'b0000;
         tick();
         if (abort_irq || !music_start) bad++;
      end
      ev_req = 4'b0;
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL tmo_early bad_cycles=%0d exp=0", bad); end
      tick();
      tests++;
      if (obs !== 8'b1000_0001) begin fails++; $display("FAIL tmo_abort obs=%b exp=%b", obs, 8'b1000_0001); end
      tick();
      tick();
      tests++;
      if (obs !== 8'b1000_0000) begin fails++; $display("FAIL tmo_gap obs=%b exp=%b", obs, 8'b1000_0000); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (obs !== 8'b0000_0000) begin fails++; $display("FAIL rst_gap obs=%b exp=%b", obs, 8'b0000_0000); end
      bad = 0;
      for (int i = 0; i < int'(GAP) + 5; i++) begin
         tick();
         if (busy) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL rst_pend_cleared busy_cycles=%0d exp=0", bad); end
   endtask

   task automatic test_end_and_preempt();
      ev_req = 4'b0001;
      tick();
      ev_req = 4'b0;
      tick();
      tick();
      ev_req = 4'b1000;
      song_end = 1'b1;
      tick();
      ev_req = 4'b0;
      song_end = 1'b0;
      tests++;
      if (obs !== 8'b1000_0010) begin fails++; $display("FAIL both_done_only obs=%b exp=%b", obs, 8'b1000_0010); end
      repeat (GAP + 2) tick();
      tests++;
      if (obs !== 8'b1111_1100) begin fails++; $display("FAIL both_play3 obs=%b exp=%b", obs, 8'b1111_1100); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (obs !== 8'b0000_0000) begin fails++; $display("FAIL rst_play obs=%b exp=%b", obs, 8'b0000_0000); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_preempt();
      test_coalesce();
      test_all4();
      test_mute();
      test_timeout_rst();
      test_end_and_preempt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
